// File: rtl/input_pulse_merger.sv
// Per-channel button conditioning: debounced active-low board key OR keyboard hold,
// registered merged level, single-cycle press pulse and optional typematic auto-repeat.
module input_pulse_merger #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] repeat_en,
  input  logic [N_CH-1:0] key_n,
  input  logic [N_CH-1:0] kb_hold,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] held,
  output logic            any_pulse
);

  // state | meaning
  // IDLE  | merged level released (or press not yet seen as a rising edge)
  // WAIT  | pressed, counting the initial delay to the first repeat
  // RPT   | pressed, emitting repeats every REPEAT_RATE cycles
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_TC = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [N_CH-1:0] sync1, sync2, key_db, kb_r, m, held_d, rise, fire, pulse_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '1;
      sync2     <= '1;
      kb_r      <= '0;
      held      <= '0;
      held_d    <= '0;
      pulse     <= '0;
      any_pulse <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      kb_r      <= kb_hold;
      held      <= m;
      held_d    <= held;
      pulse     <= pulse_nxt;
      any_pulse <= |pulse_nxt;
    end
  end

  assign m         = key_db | kb_r;
  assign rise      = held & ~held_d;
  assign pulse_nxt = {N_CH{en}} & (rise | fire);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             key_s;
    logic             db_q;
    logic [CNT_W-1:0] db_cnt;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             fire_c;

    assign key_s     = ~sync2[i];
    assign key_db[i] = db_q;
    assign fire[i]   = fire_c;

    // Counter only advances while the synced key disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_q   <= 1'b0;
        db_cnt <= '0;
      end else if (key_s == db_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        db_q   <= ~db_q;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + ONE;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire_c  = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise[i]) begin
            state_d = WAIT;
            rcnt_d  = '0;
          end
        end
        WAIT: begin
          if (!held[i]) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (!repeat_en[i]) begin
            rcnt_d = '0;
          end else if (rcnt_q == DLY_TC) begin
            // Saturate at the slot while en is low; fire as soon as it returns.
            if (en) begin
              fire_c  = 1'b1;
              rcnt_d  = '0;
              state_d = RPT;
            end
          end else begin
            rcnt_d = rcnt_q + ONE;
          end
        end
        RPT: begin
          if (!held[i]) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else if (!repeat_en[i]) begin
            rcnt_d = '0;
          end else if (rcnt_q == RATE_TC) begin
            if (en) begin
              fire_c = 1'b1;
              rcnt_d = '0;
            end
          end else begin
            rcnt_d = rcnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_pulse_merger.sv
// Bench for input_pulse_merger: scenario tasks with direct latency checks plus a
// per-cycle comparison against a history-based reference model.
module tb_input_pulse_merger;
  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int DLY  = 20;
  localparam int RATE = 8;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         en        = 1'b1;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] key_n     = '1;
  logic [N-1:0] kb_hold   = '0;
  logic [N-1:0] pulse, held;
  logic         any_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  input_pulse_merger #(
    .N_CH(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .repeat_en(repeat_en), .key_n(key_n),
    .kb_hold(kb_hold), .pulse(pulse), .held(held), .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: keeps raw sample histories and derives levels, edges and
  // repeat slots (absolute cycle numbers) from them.
  logic [N-1:0] exp_pulse = '0;
  logic [N-1:0] exp_held  = '0;
  logic         exp_any   = 1'b0;
  logic [N-1:0] kn_h[$];
  logic [N-1:0] m_h[$];
  logic [N-1:0] db = '0;
  int           next_slot[N];
  bit           rpt_ph[N];

  function automatic logic [N-1:0] kn_at(int k);
    if (k < kn_h.size()) return kn_h[k];
    return '1;
  endfunction

  function automatic logic [N-1:0] m_at(int k);
    if (k < m_h.size()) return m_h[k];
    return '0;
  endfunction

  task automatic model_clear();
    kn_h.delete();
    m_h.delete();
    db        = '0;
    exp_pulse = '0;
    exp_held  = '0;
    exp_any   = 1'b0;
    for (int c = 0; c < N; c++) begin
      next_slot[c] = -1;
      rpt_ph[c]    = 1'b0;
    end
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    logic [N-1:0] v, ndb, m1, m2, m3;
    bit all_mis, rs, fr;
    cyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      kn_h.push_front(key_n);
      if (kn_h.size() > DB + 3) void'(kn_h.pop_back());
      // accepted level flips once the last DB synced samples all disagree with it
      ndb = db;
      for (int c = 0; c < N; c++) begin
        all_mis = 1'b1;
        for (int k = 2; k <= DB + 1; k++) begin
          v = kn_at(k);
          if (v[c] != db[c]) all_mis = 1'b0;
        end
        if (all_mis) ndb[c] = ~db[c];
      end
      db = ndb;
      m_h.push_front(db | kb_hold);
      if (m_h.size() > 4) void'(m_h.pop_back());
      m1 = m_at(1);
      m2 = m_at(2);
      m3 = m_at(3);
      exp_held = m1;
      for (int c = 0; c < N; c++) begin
        rs = m2[c] & ~m3[c];
        fr = 1'b0;
        if (!m2[c]) begin
          next_slot[c] = -1;
        end else if (rs) begin
          next_slot[c] = cyc + DLY;
          rpt_ph[c]    = 1'b0;
        end else if (next_slot[c] >= 0) begin
          if (!repeat_en[c]) begin
            next_slot[c] = cyc + (rpt_ph[c] ? RATE : DLY);
          end else if (en && cyc >= next_slot[c]) begin
            fr           = 1'b1;
            next_slot[c] = cyc + RATE;
            rpt_ph[c]    = 1'b1;
          end
        end
        exp_pulse[c] = en & (rs | fr);
      end
      exp_any = |exp_pulse;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      key_n     = N'($urandom);
      kb_hold   = N'($urandom);
      repeat_en = N'($urandom);
      en        = 1'($urandom);
      #1;
      total++;
      if (pulse !== '0 || held !== '0 || any_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_assert pulse=%b held=%b any=%b want all 0", pulse, held, any_pulse);
      end
    end
    @(negedge clk);
    key_n = '1; kb_hold = '0; repeat_en = '0; en = 1'b1; rst_n = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      total++;
      if (pulse !== '0 || held !== '0 || any_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d pulse=%b held=%b any=%b want all 0", cyc, pulse, held, any_pulse);
      end
    end
  endtask

  task automatic test_debounce();
    int g, e;
    g = $urandom_range(1, DB - 1);
    @(negedge clk);
    key_n[1] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      total++;
      if (pulse !== exp_pulse || held !== exp_held || any_pulse !== exp_any) begin
        bad++;
        $display("FAIL glitch_model cyc=%0d pulse=%b held=%b any=%b want %b %b %b", cyc, pulse, held, any_pulse, exp_pulse, exp_held, exp_any);
      end
      total++;
      if (pulse[1] !== 1'b0 || held[1] !== 1'b0) begin
        bad++;
        $display("FAIL glitch_len%0d cyc=%0d pulse1=%b held1=%b want 0 0", g, cyc, pulse[1], held[1]);
      end
      if (j == g - 1) key_n[1] = 1'b1;
    end
    key_n[1] = 1'b0;
    e = cyc + 1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      total++;
      if (pulse !== exp_pulse || held !== exp_held || any_pulse !== exp_any) begin
        bad++;
        $display("FAIL debounce_model cyc=%0d pulse=%b held=%b any=%b want %b %b %b", cyc, pulse, held, any_pulse, exp_pulse, exp_held, exp_any);
      end
      if (j < 16) begin
        total++;
        if (pulse[1] !== (cyc == e + 7) || held[1] !== (cyc >= e + 6)) begin
          bad++;
          $display("FAIL debounce_latency t=E+%0d pulse1=%b held1=%b want %b %b", cyc - e, pulse[1], held[1], (cyc == e + 7), (cyc >= e + 6));
        end
      end
      if (j == 16) key_n[1] = 1'b1;
    end
  endtask

  task automatic test_merge();
    int e;
    @(negedge clk);
    kb_hold[0] = 1'b1;
    e = cyc + 1;
    for (int r = 0; r < 56; r++) begin
      @(negedge clk);
      total++;
      if (pulse !== exp_pulse || held !== exp_held || any_pulse !== exp_any) begin
        bad++;
        $display("FAIL merge_model cyc=%0d pulse=%b held=%b any=%b want %b %b %b", cyc, pulse, held, any_pulse, exp_pulse, exp_held, exp_any);
      end
      total++;
      if (pulse[0] !== (cyc == e + 2) || (r < 40 && held[0] !== (cyc >= e + 1))) begin
        bad++;
        $display("FAIL merge_handover t=E+%0d pulse0=%b held0=%b want %b %b", cyc - e, pulse[0], held[0], (cyc == e + 2), (cyc >= e + 1));
      end
      if (r == 5)  key_n[0]   = 1'b0;
      if (r == 20) kb_hold[0] = 1'b0;
      if (r == 40) key_n[0]   = 1'b1;
    end
  endtask

  task automatic test_repeat();
    int e, d;
    bit want;
    @(negedge clk);
    repeat_en[2] = 1'b1;
    kb_hold[2]   = 1'b1;
    e = cyc + 1;
    for (int j = 0; j < 76; j++) begin
      @(negedge clk);
      d = cyc - e;
      want = (d == 2 || d == 22 || d == 30 || d == 38 || d == 46 || d == 54);
      total++;
      if (pulse !== exp_pulse || held !== exp_held || any_pulse !== exp_any) begin
        bad++;
        $display("FAIL repeat_model cyc=%0d pulse=%b held=%b any=%b want %b %b %b", cyc, pulse, held, any_pulse, exp_pulse, exp_held, exp_any);
      end
      total++;
      if (pulse[2] !== want) begin
        bad++;
        $display("FAIL repeat_slot t=E+%0d pulse2=%b want %b", d, pulse[2], want);
      end
      if (cyc == e + 59) kb_hold[2] = 1'b0;
    end
    kb_hold[2] = 1'b1;
    e = cyc + 1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      total++;
      if (pulse[2] !== (cyc == e + 2)) begin
        bad++;
        $display("FAIL repeat_repress t=E+%0d pulse2=%b want %b", cyc - e, pulse[2], (cyc == e + 2));
      end
      if (j == 4) begin
        kb_hold[2]   = 1'b0;
        repeat_en[2] = 1'b0;
      end
    end
  endtask

  task automatic test_enable();
    int e;
    @(negedge clk);
    en = 1'b0;
    kb_hold[3] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      total++;
      if (pulse !== exp_pulse || held !== exp_held || any_pulse !== exp_any) begin
        bad++;
        $display("FAIL enable_model cyc=%0d pulse=%b held=%b any=%b want %b %b %b", cyc, pulse, held, any_pulse, exp_pulse, exp_held, exp_any);
      end
      total++;
      if (pulse[3] !== 1'b0 || any_pulse !== 1'b0) begin
        bad++;
        $display("FAIL enable_suppress cyc=%0d pulse3=%b any=%b want 0 0", cyc, pulse[3], any_pulse);
      end
      if (j == 10) en = 1'b1;
      if (j == 20) kb_hold[3] = 1'b0;
    end
    kb_hold[3] = 1'b1;
    e = cyc + 1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      total++;
      if (pulse[3] !== (cyc == e + 2) || any_pulse !== (cyc == e + 2)) begin
        bad++;
        $display("FAIL enable_repress t=E+%0d pulse3=%b any=%b want %b", cyc - e, pulse[3], any_pulse, (cyc == e + 2));
      end
      if (j == 5) kb_hold[3] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int e, d;
    bit want;
    @(negedge clk);
    repeat_en[1] = 1'b1;
    kb_hold[1]   = 1'b1;
    e = cyc + 1;
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      d = cyc - e;
      want = (d == 2 || d == 22 || d == 30);
      total++;
      if (pulse[1] !== want || pulse !== exp_pulse || held !== exp_held) begin
        bad++;
        $display("FAIL midrst_before t=E+%0d pulse=%b held=%b want pulse1=%b model %b %b", d, pulse, held, want, exp_pulse, exp_held);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pulse !== '0 || held !== '0 || any_pulse !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async pulse=%b held=%b any=%b want all 0", pulse, held, any_pulse);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e = cyc + 1;
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      d = cyc - e;
      want = (d == 2 || d == 22 || d == 30);
      total++;
      if (pulse[1] !== want || pulse !== exp_pulse || held !== exp_held || any_pulse !== exp_any) begin
        bad++;
        $display("FAIL midrst_after t=E+%0d pulse=%b held=%b any=%b want pulse1=%b model %b %b %b", d, pulse, held, any_pulse, want, exp_pulse, exp_held, exp_any);
      end
    end
    kb_hold[1]   = 1'b0;
    repeat_en[1] = 1'b0;
  endtask

  task automatic test_random();
    repeat_en = N'($urandom);
    for (int j = 0; j < 1500; j++) begin
      @(negedge clk);
      total++;
      if (pulse !== exp_pulse || held !== exp_held || any_pulse !== exp_any) begin
        bad++;
        $display("FAIL random_model cyc=%0d pulse=%b held=%b any=%b want %b %b %b", cyc, pulse, held, any_pulse, exp_pulse, exp_held, exp_any);
      end
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) == 0)  key_n[c]     = ~key_n[c];
        if ($urandom_range(0, 13) == 0) kb_hold[c]   = ~kb_hold[c];
        if ($urandom_range(0, 79) == 0) repeat_en[c] = ~repeat_en[c];
      end
      if ($urandom_range(0, 59) == 0) en = ~en;
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_merge();
    test_repeat();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
